// File: rtl/alu_nibble_seq.sv
// Bit-serial-by-nibble sequencer driving an external 4-bit ALU slice, LSB nibble first.
// Optional zero-result flag output enabled by defining ALU_NIBBLE_SEQ_ZERO_FLAG_EN.
module alu_nibble_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             op_s,
  input  logic                   op_m,
  input  logic                   op_cn,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic [3:0]             alu_s,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_m,
  output logic                   alu_cn,
  input  logic [3:0]             alu_f,
  input  logic                   alu_cn4,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
  ,
  output logic                   zero
`endif
);

  localparam int unsigned W = 4 * NIBBLES;
  localparam logic [2:0] IDX_LAST = 3'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [3:0]     s_q, s_d;
  logic           m_q, m_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   result_q, result_d;
  logic           cout_q, cout_d;
  logic [3:0]     nib_a, nib_b;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
  logic           zero_q, zero_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      s_q      <= '0;
      m_q      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      s_q      <= s_d;
      m_q      <= m_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  // Nibble select as an explicit mux so no operand bits go unread.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == 3'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    s_d      = s_q;
    m_d      = m_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    alu_s    = '0;
    alu_a    = '0;
    alu_b    = '0;
    alu_m    = 1'b0;
    alu_cn   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = op_s;
          m_d     = op_m;
          carry_d = op_cn;
          a_d     = op_a;
          b_d     = op_b;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        alu_s   = s_q;
        alu_m   = m_q;
        alu_a   = nib_a;
        alu_b   = nib_b;
        alu_cn  = carry_q;
        carry_d = alu_cn4;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (idx_q == 3'(i)) result_d[4*i +: 4] = alu_f;
        end
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          cout_d  = alu_cn4;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
          zero_d  = (result_d == '0);
`endif
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign result = result_q;
  assign cout   = cout_q;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
  assign zero   = zero_q;
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Scoreboard bench for alu_nibble_seq with an XOR/carry-chain ALU responder.
// Zero-flag checks are active when ALU_NIBBLE_SEQ_ZERO_FLAG_EN is defined.
module tb_alu_nibble_seq;
  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic           clk = 1'b0;
  logic           reset, start;
  logic [3:0]     op_s;
  logic           op_m, op_cn;
  logic [W-1:0]   op_a, op_b;
  logic [3:0]     alu_s, alu_a, alu_b, alu_f;
  logic           alu_m, alu_cn, alu_cn4;
  logic           busy, done, cout;
  logic [W-1:0]   result;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
  logic           zero;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           failures = 0;
  int           done_cnt = 0;
  bit           mon_en = 1'b0;
  int           resp_mode = 0;
  int           run_cyc = 0;
  logic [3:0]   la[32];
  logic         lcn[32];
  logic [W-1:0] prev_res = '0;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk(clk), .reset(reset), .start(start),
    .op_s(op_s), .op_m(op_m), .op_cn(op_cn), .op_a(op_a), .op_b(op_b),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m), .alu_cn(alu_cn),
    .alu_f(alu_f), .alu_cn4(alu_cn4),
    .busy(busy), .done(done), .result(result), .cout(cout)
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  // Responder mode 1 raises carry-out only on the first RUN cycle.
  always_comb begin
    alu_f   = alu_a ^ alu_b;
    alu_cn4 = (resp_mode == 1) ? (run_cyc == 0) : (alu_cn ^ alu_a[3]);
  end

  always @(posedge clk) run_cyc <= (busy === 1'b1) ? run_cyc + 1 : 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cn, input int mode);
    exp_t e;
    logic c;
    logic [3:0] an, bn;
    c = cn;
    e.res = '0;
    for (int i = 0; i < NIB; i++) begin
      an = a[4*i +: 4];
      bn = b[4*i +: 4];
      e.res[4*i +: 4] = an ^ bn;
      c = (mode == 1) ? (i == 0) : (c ^ an[3]);
    end
    e.cout = c;
    e.zero = (e.res == '0);
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (done === 1'b1) begin
          done_cnt++;
          if (sb_q.size() == 0) begin
            check_eq("sb_unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check_eq("done_result", result, e.res);
            check_eq("done_cout", cout, e.cout);
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
            check_eq("done_zero", zero, e.zero);
`endif
          end
        end
        if (busy !== 1'b1)
          check_eq("alu_idle", {alu_s, alu_a, alu_b, alu_m, alu_cn}, 32'd0);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] s, input logic m, input logic cn);
    exp_t e;
    logic [W-1:0] part;
    int n, nb, lat;
    bit seen;
    e = model(a, b, cn, resp_mode);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; op_s = s; op_m = m; op_cn = cn;
    @(negedge clk);
    start = 1'b0; op_a = ~a; op_b = ~b; op_s = ~s; op_m = ~m; op_cn = ~cn;
    nb = 0; lat = 0; seen = 1'b0; part = prev_res;
    for (n = 1; n <= 20 && !seen; n++) begin
      if (busy === 1'b1) begin
        if (nb < 32) begin
          la[nb]  = alu_a;
          lcn[nb] = alu_cn;
        end
        check_eq("res_partial", result, part);
        if (nb == 0) check_eq("alu_sm", {alu_s, alu_m}, {s, m});
        if (nb < int'(NIB)) part[4*nb +: 4] = e.res[4*nb +: 4];
        nb++;
        start = (nb == 2);
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        lat = n;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
    check_eq("done_seen", seen, 1);
    check_eq("latency", lat, NIB + 1);
    check_eq("busy_len", nb, NIB);
    @(negedge clk);
    check_eq("hold_result", result, e.res);
    check_eq("hold_cout", cout, e.cout);
    check_eq("idle_after", {busy, done}, 0);
    prev_res = e.res;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "time limit");
  end

  initial begin : stim
    exp_t e1, e2;
    int cnt0, d1, d2, b2;
    bit idle_ok;
    logic [W-1:0] ra, rb;
    logic [3:0] rs;
    reset = 1'b1; start = 1'b0; op_s = '0; op_m = 1'b0; op_cn = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_result", result, 0);
    check_eq("rst_cout", cout, 0);
    check_eq("rst_busy_done", {busy, done}, 0);
    check_eq("rst_alu", {alu_s, alu_a, alu_b, alu_m, alu_cn}, 0);
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
    check_eq("rst_zero", zero, 0);
`endif
    start = 1'b1; op_a = 16'hFFFF; op_b = 16'h1234;
    @(negedge clk);
    check_eq("rst_over_start", {busy, done}, 0);
    reset = 1'b0; start = 1'b0;
    mon_en = 1'b1;

    do_op(16'h1234, 16'h00FF, 4'h9, 1'b0, 1'b0);
    check_eq("seq_alu_a", {la[0], la[1], la[2], la[3]}, 16'h4321);
    check_eq("res_12CB", result, 16'h12CB);

    resp_mode = 1;
    do_op(16'h5A3C, 16'h1111, 4'h3, 1'b1, 1'b0);
    check_eq("seq_alu_cn", {lcn[0], lcn[1], lcn[2], lcn[3]}, 4'b0100);
    check_eq("mode1_cout", cout, 0);
    resp_mode = 0;

    do_op(16'hFFFF, 16'h0000, 4'h0, 1'b0, 1'b1);
    check_eq("ones_cout", cout, 1);
    do_op(16'hA5A5, 16'hA5A5, 4'h6, 1'b1, 1'b0);
    check_eq("res_zero", result, 0);
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
    check_eq("zero_set", zero, 1);
`endif
    do_op(16'h0001, 16'h0000, 4'h6, 1'b1, 1'b0);
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
    check_eq("zero_clr", zero, 0);
`endif

    for (int k = 0; k < 6; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 4'($urandom);
      do_op(ra, rb, rs, 1'($urandom), 1'($urandom));
    end

    // Back-to-back with start held high; operands change mid-run.
    cnt0 = done_cnt;
    e1 = model(16'hBEEF, 16'h0F0F, 1'b0, 0);
    e2 = model(16'h1357, 16'h2468, 1'b1, 0);
    sb_q.push_back(e1);
    @(negedge clk);
    start = 1'b1; op_a = 16'hBEEF; op_b = 16'h0F0F; op_cn = 1'b0; op_s = 4'h2; op_m = 1'b0;
    @(negedge clk);
    op_a = 16'h1357; op_b = 16'h2468; op_cn = 1'b1;
    sb_q.push_back(e2);
    d1 = 0; d2 = 0; b2 = 0; idle_ok = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (done === 1'b1) begin
        if (d1 == 0) d1 = n;
        else if (d2 == 0) d2 = n;
      end
      if (d1 != 0 && n == d1 + 1) idle_ok = (busy === 1'b0) && (done === 1'b0);
      if (d1 != 0 && busy === 1'b1 && b2 == 0) begin
        b2 = n;
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("b2b_first_done", d1, NIB + 1);
    check_eq("b2b_idle_gap", idle_ok, 1);
    check_eq("b2b_restart", b2, d1 + 2);
    check_eq("b2b_second_done", d2, d1 + NIB + 2);
    check_eq("b2b_done_count", done_cnt - cnt0, 2);
    check_eq("b2b_result", result, e2.res);
    prev_res = e2.res;

    // Reset on the second RUN cycle aborts the operation.
    cnt0 = done_cnt;
    @(negedge clk);
    start = 1'b1; op_a = 16'h7777; op_b = 16'h1111; op_cn = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_busy_pre", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_done", done, 0);
    check_eq("rst_mid_result", result, 0);
    check_eq("rst_mid_cout", cout, 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("rst_mid_no_done", done_cnt - cnt0, 0);
    prev_res = '0;

    do_op(16'hC0DE, 16'h3210, 4'hA, 1'b0, 1'b1);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
